// File: rtl/stream_merge2_pkg.sv
// Shared types for the two-input round-robin stream merger.
// Source index encoding and the arbitration pointer reset value.
package stream_merge2_pkg;

   typedef enum logic {
      SRC_D0 = 1'b0,
      SRC_D1 = 1'b1
   } src_e;

   // Pointer starts at d1 so that d0 wins the first contention.
   localparam src_e RST_LAST_GRANT = SRC_D1;

endpackage

// File: rtl/stream_merge2_rr_arb2.sv
// Two-requester round-robin arbiter that owns the last_grant pointer.
// The pointer moves only when the caller reports a completed transfer.
module rr_arb2
   import stream_merge2_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output src_e       grant,
   output logic       gnt_valid
);

   src_e last_grant;

   always_comb begin
      gnt_valid = req[0] | req[1];
      grant     = last_grant;
      case (req)
         2'b01:   grant = SRC_D0;
         2'b10:   grant = SRC_D1;
         2'b11:   grant = (last_grant == SRC_D0) ? SRC_D1 : SRC_D0;
         default: grant = last_grant;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= RST_LAST_GRANT;
      end else if (advance) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/stream_merge2.sv
// Round-robin 2:1 stream merger with a single-entry registered output stage.
// Define STREAM_MERGE2_COUNT_EN to add per-source accepted-word counters cnt0/cnt1.
module stream_merge2
   import stream_merge2_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d0,
   input  logic             d0_valid,
   output logic             d0_ready,
   input  logic [WIDTH-1:0] d1,
   input  logic             d1_valid,
   output logic             d1_ready,
   output logic             sel,
   output logic [WIDTH-1:0] z,
   output logic             z_valid,
   input  logic             z_ready,
   output logic             z_src
`ifdef STREAM_MERGE2_COUNT_EN
   ,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
`endif
);

   if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
      $error("stream_merge2: WIDTH and CNT_W must be positive");
   end

   src_e             grant;
   logic             gnt_valid;
   logic             accept;
   logic             xfer;
   logic [WIDTH-1:0] gnt_data;

   logic [WIDTH-1:0] z_p0;
   src_e             src_p0;
   logic             vld_p0;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       ({d1_valid, d0_valid}),
      .advance   (xfer),
      .grant     (grant),
      .gnt_valid (gnt_valid)
   );

   // Output slot can take a new word whenever it is empty or being drained.
   assign accept   = !vld_p0 || z_ready;
   assign xfer     = accept && gnt_valid;
   assign d0_ready = accept && d0_valid && (grant == SRC_D0);
   assign d1_ready = accept && d1_valid && (grant == SRC_D1);
   assign sel      = grant;
   assign gnt_data = (grant == SRC_D1) ? d1 : d0;

   // Stage p0: output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_p0   <= '0;
         src_p0 <= SRC_D0;
         vld_p0 <= 1'b0;
      end else if (xfer) begin
         z_p0   <= gnt_data;
         src_p0 <= grant;
         vld_p0 <= 1'b1;
      end else if (z_ready) begin
         vld_p0 <= 1'b0;
      end
   end

   assign z       = z_p0;
   assign z_src   = src_p0;
   assign z_valid = vld_p0;

`ifdef STREAM_MERGE2_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (d0_ready) cnt0 <= cnt0 + CNT_W'(1);
         if (d1_ready) cnt1 <= cnt1 + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_stream_merge2.sv
// Directed bench for stream_merge2: contention, backpressure, drain, single source, reset.
// Counter checks are compiled in when STREAM_MERGE2_COUNT_EN is defined.
module tb_stream_merge2;

   localparam int WIDTH = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [WIDTH-1:0] d0 = '0;
   logic             d0_valid = 1'b0;
   logic             d0_ready;
   logic [WIDTH-1:0] d1 = '0;
   logic             d1_valid = 1'b0;
   logic             d1_ready;
   logic             sel;
   logic [WIDTH-1:0] z;
   logic             z_valid;
   logic             z_ready = 1'b0;
   logic             z_src;
`ifdef STREAM_MERGE2_COUNT_EN
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_merge2 #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .d0       (d0),
      .d0_valid (d0_valid),
      .d0_ready (d0_ready),
      .d1       (d1),
      .d1_valid (d1_valid),
      .d1_ready (d1_ready),
      .sel      (sel),
      .z        (z),
      .z_valid  (z_valid),
      .z_ready  (z_ready),
      .z_src    (z_src)
`ifdef STREAM_MERGE2_COUNT_EN
      ,
      .cnt0     (cnt0),
      .cnt1     (cnt1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #1 rst_n = 1'b0;
      #3;
      check("rst_z_valid", 32'(z_valid), 32'h0);
      check("rst_z", 32'(z), 32'h0);
      check("rst_z_src", 32'(z_src), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Contention: first grant goes to d0, then strict alternation
      @(negedge clk);
      d0 = 8'h11; d1 = 8'h22; d0_valid = 1'b1; d1_valid = 1'b1; z_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("cont_sel%0d", i), 32'(sel), 32'(i % 2));
         check($sformatf("cont_rdy%0d", i), 32'({d1_ready, d0_ready}), (i % 2) ? 32'h2 : 32'h1);
         after_edge();
         check($sformatf("cont_z%0d", i), 32'(z), (i % 2) ? 32'h22 : 32'h11);
         check($sformatf("cont_src%0d", i), 32'(z_src), 32'(i % 2));
         @(negedge clk);
      end

      // Load 0x11, then stall for three cycles with both inputs still valid
      after_edge();
      check("bp_load", 32'(z), 32'h11);
      @(negedge clk);
      z_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp_rdy%0d", i), 32'({d1_ready, d0_ready}), 32'h0);
         after_edge();
         check($sformatf("bp_z%0d", i), 32'(z), 32'h11);
         check($sformatf("bp_vld%0d", i), 32'(z_valid), 32'h1);
         @(negedge clk);
      end
      z_ready = 1'b1;
      #1;
      check("bp_rel_sel", 32'(sel), 32'h1);
      check("bp_rel_d1rdy", 32'(d1_ready), 32'h1);
      after_edge();
      check("bp_rel_z", 32'(z), 32'h22);
      check("bp_rel_src", 32'(z_src), 32'h1);

      // Drain: one word from d1, then nothing valid
      @(negedge clk);
      d0_valid = 1'b0; d1 = 8'h3C;
      after_edge();
      check("drn_z", 32'(z), 32'h3C);
      check("drn_vld", 32'(z_valid), 32'h1);
      check("drn_src", 32'(z_src), 32'h1);
      @(negedge clk);
      d1_valid = 1'b0;
      after_edge();
      check("drn_vld_off", 32'(z_valid), 32'h0);
      check("drn_z_hold", 32'(z), 32'h3C);
      check("drn_src_hold", 32'(z_src), 32'h1);

      // Single source d0 for four cycles
      @(negedge clk);
      d0 = 8'hA5; d0_valid = 1'b1;
      #1;
      check("ss_d0rdy", 32'(d0_ready), 32'h1);
      check("ss_sel", 32'(sel), 32'h0);
      for (int i = 0; i < 4; i++) begin
         after_edge();
         check($sformatf("ss_z%0d", i), 32'(z), 32'hA5);
         check($sformatf("ss_src%0d", i), 32'(z_src), 32'h0);
         check($sformatf("ss_d1rdy%0d", i), 32'(d1_ready), 32'h0);
      end

      // Idle: sel shows the pointer (last grant d0); then contention goes to d1
      @(negedge clk);
      d0_valid = 1'b0;
      #1;
      check("idle_sel", 32'(sel), 32'h0);
      check("idle_rdy", 32'({d1_ready, d0_ready}), 32'h0);
      @(negedge clk);
      d0 = 8'h11; d1 = 8'h22; d0_valid = 1'b1; d1_valid = 1'b1;
      #1;
      check("fair_sel", 32'(sel), 32'h1);
      after_edge();
      check("fair_z", 32'(z), 32'h22);

      // Async reset mid-run with a word held in z
      #2 rst_n = 1'b0;
      #1;
      check("mrst_vld", 32'(z_valid), 32'h0);
      check("mrst_z", 32'(z), 32'h0);
      check("mrst_src", 32'(z_src), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mrst_sel", 32'(sel), 32'h0);
      after_edge();
      check("mrst_z1", 32'(z), 32'h11);
      check("mrst_src1", 32'(z_src), 32'h0);

`ifdef STREAM_MERGE2_COUNT_EN
      // Counters: 5 d0 and 3 d1 transfers after a fresh reset
      @(negedge clk);
      d0_valid = 1'b0; d1_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("cnt0_rst", 32'(cnt0), 32'h0);
      check("cnt1_rst", 32'(cnt1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      d1_valid = 1'b1;
      for (int i = 0; i < 3; i++) after_edge();
      @(negedge clk);
      d1_valid = 1'b0; d0_valid = 1'b1;
      for (int i = 0; i < 5; i++) after_edge();
      check("cnt0_5", 32'(cnt0), 32'd5);
      check("cnt1_3", 32'(cnt1), 32'd3);
      // Run d0 up to 2^CNT_W-1, then one more transfer wraps it
      for (int i = 0; i < 65530; i++) after_edge();
      check("cnt0_max", 32'(cnt0), 32'hFFFF);
      after_edge();
      check("cnt0_wrap", 32'(cnt0), 32'h0);
      check("cnt1_hold", 32'(cnt1), 32'd3);
      @(negedge clk);
      d0_valid = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
